// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and constants for the accelerator memory arbiter
package acc_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  // Image layout in the shared memory: input image first, edge map after it.
  localparam int IMG_ROW_WORDS = 88;
  localparam int IMG_ROWS      = 288;
  localparam int IMG_OUT_BASE  = 25344;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    RUN     = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

endpackage

// File: rtl/acc_mem_arbiter_if.sv
// rtl/acc_mem_arbiter_if.sv - host, accelerator and memory signals of the arbiter
// slave  : arbiter side (takes host/accelerator requests, drives memory port)
// master : environment side (host, accelerator and memory models)
interface acc_mem_arbiter_if;
  import acc_pkg::*;

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;
  logic              h_start;
  logic              h_busy;
  logic              h_done;
  logic              h_timeout;

  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_dataW;
  logic              a_en;
  logic              a_we;
  logic [DATA_W-1:0] a_dataR;
  logic              a_start;
  logic              a_finish;
  logic              a_reset;

  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dataW;
  logic              m_en;
  logic              m_we;
  logic [DATA_W-1:0] m_dataR;

  modport slave (
    input  h_req, h_we, h_addr, h_wdata, h_start,
    input  a_addr, a_dataW, a_en, a_we, a_finish,
    input  m_dataR,
    output h_gnt, h_rvalid, h_rdata, h_busy, h_done, h_timeout,
    output a_dataR, a_start, a_reset,
    output m_addr, m_dataW, m_en, m_we
  );

  modport master (
    output h_req, h_we, h_addr, h_wdata, h_start,
    output a_addr, a_dataW, a_en, a_we, a_finish,
    output m_dataR,
    input  h_gnt, h_rvalid, h_rdata, h_busy, h_done, h_timeout,
    input  a_dataR, a_start, a_reset,
    input  m_addr, m_dataW, m_en, m_we
  );

endinterface

// File: rtl/acc_watchdog.sv
// rtl/acc_watchdog.sv - job watchdog counter with terminal-count pulse
// clk, reset : clock, asynchronous active-high reset
// clr_i      : clear count (job launch)
// en_i       : count this cycle (job running)
// tc_o       : this enabled cycle brings the count to 2^TIMEOUT_W-1
module acc_watchdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TIMEOUT_W-1:0] ONE     = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] LAST_TC = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  // Fire on the increment that reaches all-ones, so a job that never
  // finishes leaves RUN after exactly 2^TIMEOUT_W-1 RUN cycles.
  assign tc_o = en_i && (cnt_q == LAST_TC);

endmodule

// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - shares the image memory between host and accelerator and sequences jobs
// clk, reset : clock, asynchronous active-high reset
// bus        : host port (h_*), accelerator port (a_*), memory port (m_*)
module acc_mem_arbiter
  import acc_pkg::*;
#(
  parameter int TIMEOUT_W = 20
) (
  input  logic            clk,
  input  logic            reset,
  acc_mem_arbiter_if.slave bus
);

  arb_state_t state_q;
  logic       h_rvalid_q;
  logic       h_done_q;
  logic       h_timeout_q;
  logic       rst_q;
  logic       fin_q;     // last RECOVER was caused by a_finish, not the watchdog
  logic       wd_tc;

  acc_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == LAUNCH),
    .en_i  (state_q == RUN),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      h_rvalid_q  <= 1'b0;
      h_done_q    <= 1'b0;
      h_timeout_q <= 1'b0;
      rst_q       <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      // Host reads are only granted in IDLE; data returns next cycle whatever the state.
      h_rvalid_q <= (state_q == IDLE) && bus.h_req && !bus.h_we;
      h_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.h_start) begin
            state_q     <= LAUNCH;
            h_timeout_q <= 1'b0;
          end
        end
        LAUNCH: begin
          state_q <= RUN;
        end
        RUN: begin
          // a_finish has priority over a coincident watchdog expiry.
          if (bus.a_finish) begin
            state_q <= RECOVER;
            rst_q   <= 1'b1;
            fin_q   <= 1'b1;
          end else if (wd_tc) begin
            state_q     <= RECOVER;
            rst_q       <= 1'b1;
            fin_q       <= 1'b0;
            h_timeout_q <= 1'b1;
          end
        end
        RECOVER: begin
          state_q  <= IDLE;
          rst_q    <= 1'b0;
          h_done_q <= fin_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The accelerator has no stall input, so in LAUNCH/RUN it gets the port with no added latency.
  always_comb begin
    bus.m_addr  = bus.h_addr;
    bus.m_dataW = bus.h_wdata;
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.h_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.m_en  = bus.h_req;
        bus.m_we  = bus.h_req && bus.h_we;
        bus.h_gnt = bus.h_req;
      end
      LAUNCH, RUN: begin
        bus.m_addr  = bus.a_addr;
        bus.m_dataW = bus.a_dataW;
        bus.m_en    = bus.a_en;
        bus.m_we    = bus.a_we;
      end
      default: begin
      end
    endcase
  end

  assign bus.a_dataR   = bus.m_dataR;
  assign bus.h_rdata   = bus.m_dataR;
  assign bus.h_rvalid  = h_rvalid_q;
  assign bus.h_done    = h_done_q;
  assign bus.h_timeout = h_timeout_q;
  assign bus.h_busy    = (state_q != IDLE);
  assign bus.a_start   = (state_q == LAUNCH);
  assign bus.a_reset   = reset | rst_q;

endmodule
